// File: rtl/iq_accumulator.sv
// IQ window accumulator: after a trigger, skips a programmable number of valid
// samples, then integrates a window of signed I/Q samples into saturating
// sums. Each completed window publishes the packed sums with a one-cycle strobe.
module iq_accumulator #(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned ACC_W    = 32,
    parameter int unsigned LEN_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  trigger,
    input  logic [LEN_W-1:0]      start_delay,
    input  logic [LEN_W-1:0]      window_len,
    input  logic                  sample_valid,
    input  logic [SAMPLE_W-1:0]   sample_i,
    input  logic [SAMPLE_W-1:0]   sample_q,
    output logic [2*ACC_W-1:0]    accumulated_input,
    output logic                  stb_start,
    output logic                  busy,
    output logic                  sat_flag,
    output logic                  trig_drop
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDelay = 2'd1,
        StAccum = 2'd2
    } state_t;

    state_t               r_state;
    logic [LEN_W-1:0]     r_len;
    logic [LEN_W-1:0]     r_delay;
    logic [LEN_W-1:0]     r_cnt;
    logic [ACC_W-1:0]     r_sum_i;
    logic [ACC_W-1:0]     r_sum_q;
    logic                 r_sat;
    logic [2*ACC_W-1:0]   r_acc;
    logic                 r_stb;
    logic                 r_sat_flag;
    logic                 r_trig_drop;

    // {overflow, clamped sum} for each channel
    logic [ACC_W:0]       w_add_i;
    logic [ACC_W:0]       w_add_q;
    logic                 w_ovf_i;
    logic                 w_ovf_q;
    logic [ACC_W-1:0]     w_next_i;
    logic [ACC_W-1:0]     w_next_q;

    // Signed add of a sign-extended sample into an accumulator, clamped to the
    // ACC_W range. The MSB of the result flags that a clamp happened.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0]    acc,
                                               input logic [SAMPLE_W-1:0] smp);
        logic [ACC_W:0] ext_a;
        logic [ACC_W:0] ext_s;
        logic [ACC_W:0] sum;
        ext_a = {acc[ACC_W-1], acc};
        ext_s = {{(ACC_W + 1 - SAMPLE_W){smp[SAMPLE_W-1]}}, smp};
        sum   = ext_a + ext_s;
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            if (sum[ACC_W]) begin
                return {1'b1, 1'b1, {(ACC_W - 1){1'b0}}};
            end
            return {1'b1, 1'b0, {(ACC_W - 1){1'b1}}};
        end
        return {1'b0, sum[ACC_W-1:0]};
    endfunction

    // Saturating next-sum for both channels
    always_comb begin
        w_add_i  = sat_add(r_sum_i, sample_i);
        w_add_q  = sat_add(r_sum_q, sample_q);
        w_ovf_i  = w_add_i[ACC_W];
        w_ovf_q  = w_add_q[ACC_W];
        w_next_i = w_add_i[ACC_W-1:0];
        w_next_q = w_add_q[ACC_W-1:0];
    end

    // Capture FSM: state, working sums, counters and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_len       <= '0;
            r_delay     <= '0;
            r_cnt       <= '0;
            r_sum_i     <= '0;
            r_sum_q     <= '0;
            r_sat       <= 1'b0;
            r_acc       <= '0;
            r_stb       <= 1'b0;
            r_sat_flag  <= 1'b0;
            r_trig_drop <= 1'b0;
        end else begin
            r_stb <= 1'b0;
            // A trigger during a capture is dropped but remembered
            if (trigger && (r_state != StIdle)) begin
                r_trig_drop <= 1'b1;
            end
            unique case (r_state)
                StIdle: begin
                    if (trigger && (window_len != '0)) begin
                        r_len       <= window_len;
                        r_delay     <= start_delay;
                        r_cnt       <= '0;
                        r_sum_i     <= '0;
                        r_sum_q     <= '0;
                        r_sat       <= 1'b0;
                        r_trig_drop <= 1'b0;
                        r_state     <= (start_delay != '0) ? StDelay : StAccum;
                    end
                end
                StDelay: begin
                    if (sample_valid) begin
                        if (r_cnt == (r_delay - LEN_W'(1))) begin
                            r_cnt   <= '0;
                            r_state <= StAccum;
                        end else begin
                            r_cnt <= r_cnt + LEN_W'(1);
                        end
                    end
                end
                StAccum: begin
                    if (sample_valid) begin
                        r_sum_i <= w_next_i;
                        r_sum_q <= w_next_q;
                        r_sat   <= r_sat | w_ovf_i | w_ovf_q;
                        r_cnt   <= r_cnt + LEN_W'(1);
                        // Compare against len-1 so a full-scale length never wraps
                        if (r_cnt == (r_len - LEN_W'(1))) begin
                            r_acc      <= {w_next_q, w_next_i};
                            r_sat_flag <= r_sat | w_ovf_i | w_ovf_q;
                            r_stb      <= 1'b1;
                            r_cnt      <= '0;
                            r_state    <= StIdle;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign accumulated_input = r_acc;
    assign stb_start         = r_stb;
    assign busy              = (r_state != StIdle);
    assign sat_flag          = r_sat_flag;
    assign trig_drop         = r_trig_drop;

endmodule

// File: tb/tb_iq_accumulator.sv
// Directed bench for iq_accumulator: expected windows are queued when the last
// sample is driven and compared when the strobe appears.
module tb_iq_accumulator;

    typedef struct {
        logic [63:0] acc;
        logic        sat;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        q32[$];
    exp_t        q16[$];
    logic [63:0] last_acc;

    // 32-bit accumulator instance
    logic        trigger = 1'b0;
    logic [15:0] start_delay = '0;
    logic [15:0] window_len = '0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_i = '0;
    logic [15:0] sample_q = '0;
    logic [63:0] acc32;
    logic        stb32, busy32, sat32, tdrop32;

    // 16-bit accumulator instance for saturation and full-length windows
    logic        t16_trigger = 1'b0;
    logic [15:0] t16_len = '0;
    logic        t16_valid = 1'b0;
    logic [15:0] t16_i = '0;
    logic [15:0] t16_q = '0;
    logic [31:0] acc16;
    logic        stb16, busy16, sat16, tdrop16;

    iq_accumulator #(.SAMPLE_W(16), .ACC_W(32), .LEN_W(16)) dut32 (
        .clk               (clk),
        .rst_n             (rst_n),
        .trigger           (trigger),
        .start_delay       (start_delay),
        .window_len        (window_len),
        .sample_valid      (sample_valid),
        .sample_i          (sample_i),
        .sample_q          (sample_q),
        .accumulated_input (acc32),
        .stb_start         (stb32),
        .busy              (busy32),
        .sat_flag          (sat32),
        .trig_drop         (tdrop32)
    );

    iq_accumulator #(.SAMPLE_W(16), .ACC_W(16), .LEN_W(16)) dut16 (
        .clk               (clk),
        .rst_n             (rst_n),
        .trigger           (t16_trigger),
        .start_delay       (16'd0),
        .window_len        (t16_len),
        .sample_valid      (t16_valid),
        .sample_i          (t16_i),
        .sample_q          (t16_q),
        .accumulated_input (acc16),
        .stb_start         (stb16),
        .busy              (busy16),
        .sat_flag          (sat16),
        .trig_drop         (tdrop16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of stimulus on the 32-bit instance
    task automatic drive(input logic trg, input logic v, input int si, input int sq);
        trigger      = trg;
        sample_valid = v;
        sample_i     = 16'(si);
        sample_q     = 16'(sq);
        tick();
        trigger      = 1'b0;
        sample_valid = 1'b0;
    endtask

    task automatic push32(input logic [63:0] acc, input logic sat);
        q32.push_back('{acc: acc, sat: sat, cyc: cyc + 1});
    endtask

    task automatic push16(input logic [31:0] acc, input logic sat);
        q16.push_back('{acc: {32'd0, acc}, sat: sat, cyc: cyc + 1});
    endtask

    // Scoreboard consumer for the 32-bit instance
    always @(negedge clk) begin
        if (stb32) begin
            check("stb32_expected", 64'(q32.size() != 0), 64'd1);
            if (q32.size() != 0) begin
                exp_t e;
                e = q32.pop_front();
                check("acc32", acc32, e.acc);
                check("sat32", 64'(sat32), 64'(e.sat));
                check("lat32", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Scoreboard consumer for the 16-bit instance
    always @(negedge clk) begin
        if (stb16) begin
            check("stb16_expected", 64'(q16.size() != 0), 64'd1);
            if (q16.size() != 0) begin
                exp_t e;
                e = q16.pop_front();
                check("acc16", 64'(acc16), e.acc);
                check("sat16", 64'(sat16), 64'(e.sat));
                check("lat16", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        // Reset state
        #12;
        check("rst_acc", acc32, 64'd0);
        check("rst_stb", 64'(stb32), 64'd0);
        check("rst_busy", 64'(busy32), 64'd0);
        check("rst_sat", 64'(sat32), 64'd0);
        check("rst_tdrop", 64'(tdrop32), 64'd0);
        rst_n = 1'b1;
        tick();
        tick();

        // Basic window, no delay, continuous valid
        start_delay = 16'd0;
        window_len  = 16'd4;
        drive(1'b1, 1'b0, 0, 0);
        check("w1_busy", 64'(busy32), 64'd1);
        drive(1'b0, 1'b1, 1, -1);
        drive(1'b0, 1'b1, 2, -2);
        drive(1'b0, 1'b1, 3, -3);
        push32({32'hFFFFFFF6, 32'h0000000A}, 1'b0);
        drive(1'b0, 1'b1, 4, -4);
        tick();
        tick();
        check("w1_idle", 64'(busy32), 64'd0);
        check("w1_done", 64'(q32.size()), 64'd0);

        // Delay of two gapped samples, then three gapped samples
        start_delay = 16'd2;
        window_len  = 16'd3;
        drive(1'b1, 1'b0, 0, 0);
        drive(1'b0, 1'b1, 100, -2);
        check("w2_busy_delay", 64'(busy32), 64'd1);
        drive(1'b0, 1'b0, 999, 999);
        drive(1'b0, 1'b1, 100, -2);
        drive(1'b0, 1'b0, 999, 999);
        drive(1'b0, 1'b1, 5, -2);
        drive(1'b0, 1'b0, 999, 999);
        drive(1'b0, 1'b1, 6, -2);
        drive(1'b0, 1'b0, 999, 999);
        push32({32'hFFFFFFFA, 32'd18}, 1'b0);
        drive(1'b0, 1'b1, 7, -2);
        tick();
        tick();
        check("w2_done", 64'(q32.size()), 64'd0);
        last_acc = {32'hFFFFFFFA, 32'd18};

        // Zero-length trigger is ignored
        start_delay = 16'd0;
        window_len  = 16'd0;
        drive(1'b1, 1'b1, 50, 50);
        check("zl_busy", 64'(busy32), 64'd0);
        drive(1'b0, 1'b1, 50, 50);
        tick();
        check("zl_acc", acc32, last_acc);

        // Retrigger mid-window is dropped; a trigger during the strobe is accepted
        window_len = 16'd10;
        drive(1'b1, 1'b0, 0, 0);
        for (int k = 1; k <= 9; k++) begin
            if (k == 5) begin
                window_len  = 16'd2;
                start_delay = 16'd3;
                drive(1'b1, 1'b1, k, -k);
                window_len  = 16'd10;
                start_delay = 16'd0;
                check("rt_tdrop_set", 64'(tdrop32), 64'd1);
            end else begin
                drive(1'b0, 1'b1, k, -k);
            end
        end
        push32({32'hFFFFFFC9, 32'd55}, 1'b0);
        drive(1'b0, 1'b1, 10, -10);
        check("rt_tdrop_hold", 64'(tdrop32), 64'd1);
        window_len = 16'd1;
        drive(1'b1, 1'b0, 0, 0);
        check("rt_tdrop_clr", 64'(tdrop32), 64'd0);
        check("rt_busy", 64'(busy32), 64'd1);
        push32({32'd3, 32'd9}, 1'b0);
        drive(1'b0, 1'b1, 9, 3);
        tick();
        tick();
        check("rt_done", 64'(q32.size()), 64'd0);

        // Reset mid-window discards everything
        window_len = 16'd5;
        drive(1'b1, 1'b0, 0, 0);
        drive(1'b0, 1'b1, 11, 12);
        drive(1'b1, 1'b1, 13, 14);
        check("mr_tdrop", 64'(tdrop32), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_acc", acc32, 64'd0);
        check("mr_busy", 64'(busy32), 64'd0);
        check("mr_stb", 64'(stb32), 64'd0);
        check("mr_sat", 64'(sat32), 64'd0);
        check("mr_tdrop0", 64'(tdrop32), 64'd0);
        tick();
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 20, 20);
        check("mr_stays_idle", 64'(busy32), 64'd0);
        window_len = 16'd1;
        drive(1'b1, 1'b0, 0, 0);
        push32({32'd0, 32'd7}, 1'b0);
        drive(1'b0, 1'b1, 7, 0);
        tick();
        tick();
        check("mr_done", 64'(q32.size()), 64'd0);

        // Full-length window on the 16-bit instance saturates both channels
        t16_len     = 16'hFFFF;
        t16_trigger = 1'b1;
        tick();
        t16_trigger = 1'b0;
        t16_valid   = 1'b1;
        t16_i       = 16'h7FFF;
        t16_q       = 16'h8000;
        for (int k = 0; k < 65534; k++) tick();
        check("sat_busy_late", 64'(busy16), 64'd1);
        push16({16'h8000, 16'h7FFF}, 1'b1);
        tick();
        t16_valid = 1'b0;
        tick();
        tick();
        check("sat_done", 64'(q16.size()), 64'd0);
        check("sat_idle", 64'(busy16), 64'd0);

        // Following small window clears the saturation flag
        t16_len     = 16'd2;
        t16_trigger = 1'b1;
        tick();
        t16_trigger = 1'b0;
        t16_valid   = 1'b1;
        t16_i       = 16'd1;
        t16_q       = 16'd0;
        tick();
        t16_i = 16'd2;
        push16({16'h0000, 16'h0003}, 1'b0);
        tick();
        t16_valid = 1'b0;
        tick();
        tick();
        check("small_done", 64'(q16.size()), 64'd0);
        check("q32_empty", 64'(q32.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
